instr_fetch_ctrl: RTL and testbench

- Fetch sequencer for the 1024-word synchronous-read instruction ROM.
- Generates the word address every cycle and tracks the PC of the word in flight.
- Presents instruction + PC + valid to decode.
- Handles downstream stall (address replay), branch/jump redirect (zero bubble), and halt/resume.
- Sits between the ROM instance (external) and the decode stage.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/instr_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer state encoding and the ROM geometry defaults.
package cpu_pkg;

  localparam int CPU_ADDR_WIDTH = 10;
  localparam int CPU_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for the synchronous-read instruction ROM: issues word addresses,
// tracks the PC of the word in flight, and handles stall replay, redirect and halt.
//
// state  | meaning
// BOOT   | first cycle after reset, RESET_PC (or a redirect target) is being read
// RUN    | streaming sequential words to decode
// HALTED | fetch stopped, instr_valid low, only a redirect resumes
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  halt_req,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                  out_valid_q, out_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      out_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Replaying out_pc while stalled makes the ROM re-present the same word.
  always_comb begin
    if (redirect_valid)
      mem_addr = redirect_addr;
    else if (state_q == BOOT)
      mem_addr = RESET_PC;
    else if ((stall && out_valid_q) || state_q == HALTED)
      mem_addr = out_pc_q;
    else
      mem_addr = fetch_pc_q;
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      BOOT: begin
        if (redirect_valid) begin
          out_pc_d   = redirect_addr;
          fetch_pc_d = redirect_addr + PC_ONE;
        end else begin
          out_pc_d   = RESET_PC;
          fetch_pc_d = RESET_PC + PC_ONE;
        end
        out_valid_d = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          out_pc_d    = redirect_addr;
          fetch_pc_d  = redirect_addr + PC_ONE;
          out_valid_d = 1'b1;
        end else if (stall && out_valid_q) begin
          state_d = RUN;
        end else if (halt_req) begin
          out_valid_d = 1'b0;
          state_d     = HALTED;
        end else begin
          out_pc_d    = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + PC_ONE;
          out_valid_d = 1'b1;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          out_pc_d    = redirect_addr;
          fetch_pc_d  = redirect_addr + PC_ONE;
          out_valid_d = 1'b1;
          state_d     = RUN;
        end
      end
      default: begin
        state_d     = BOOT;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign instr       = mem_data;
  assign instr_pc    = out_pc_q;
  assign instr_valid = out_valid_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus random traffic, every cycle
// compared with a behavioural model of the fetch rules and a 1-cycle ROM model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        stall;
  logic        redirect_valid;
  logic [9:0]  redirect_addr;
  logic        halt_req;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  // model: mode 0 = just reset, 1 = streaming, 2 = stopped
  int m_mode  = 0;
  bit m_valid = 0;
  int m_pc    = 0;
  int m_next  = 0;
  bit m_known = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= 32'hA000_0000 + 32'(mem_addr);

  instr_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .halt_req      (halt_req),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit stl, input bit rdv, input int ra, input bit hlt);
    int exp_addr;
    @(negedge clk);
    rst_n          = ~rst;
    stall          = stl;
    redirect_valid = rdv;
    redirect_addr  = 10'(ra);
    halt_req       = hlt;
    #1;
    if (m_known) begin
      if (rdv)                                exp_addr = ra;
      else if (m_mode == 0)                   exp_addr = 0;
      else if ((stl && m_valid) || m_mode == 2) exp_addr = m_pc;
      else                                    exp_addr = m_next;
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_mode == 2));
      if (m_valid) begin
        chk("instr_pc", 32'(instr_pc), 32'(m_pc));
        chk("instr", instr, 32'hA000_0000 + 32'(m_pc));
      end
    end
    if (rst) begin
      m_mode = 0; m_valid = 0; m_pc = 0; m_next = 0; m_known = 1;
    end else if (m_known) begin
      if (m_mode == 0) begin
        m_pc = rdv ? ra : 0;
        m_next = (m_pc + 1) % 1024; m_valid = 1; m_mode = 1;
      end else if (rdv) begin
        m_pc = ra; m_next = (ra + 1) % 1024; m_valid = 1; m_mode = 1;
      end else if (m_mode == 1) begin
        if (stl && m_valid) begin
          m_mode = 1;
        end else if (hlt) begin
          m_valid = 0; m_mode = 2;
        end else begin
          m_pc = m_next; m_next = (m_next + 1) % 1024; m_valid = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_pc(input int target);
    int n = 0;
    while (!(m_valid && m_pc == target) && n < 64) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
    if (n >= 64) chk("run_until_timeout", 32'(m_pc), 32'(target));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; halt_req = 1'b0;

    // reset, then free run from 0
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("boot_pc0", 32'(instr_pc), 32'd0);
    chk("boot_instr0", instr, 32'hA000_0000);
    for (int i = 1; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("seq_pc", 32'(instr_pc), 32'(i));
    end

    // stall for 3 cycles on pc 5
    run_until_pc(5);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk("stall_pc", 32'(instr_pc), 32'd5);
      chk("stall_instr", instr, 32'hA000_0005);
    end
    cycle(0, 0, 0, 0, 0);
    chk("post_stall_6", 32'(instr_pc), 32'd6);
    cycle(0, 0, 0, 0, 0);
    chk("post_stall_7", 32'(instr_pc), 32'd7);

    // redirect beats stall and halt_req
    cycle(0, 1, 1, 'h200, 1);
    chk("redir_pc", 32'(instr_pc), 32'h200);
    chk("redir_instr", instr, 32'hA000_0200);
    chk("redir_halted", 32'(halted), 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("redir_next", 32'(instr_pc), 32'h201);

    // wrap-around
    cycle(0, 0, 1, 1022, 0);
    chk("wrap_1022", 32'(instr_pc), 32'd1022);
    cycle(0, 0, 0, 0, 0);
    chk("wrap_1023", 32'(instr_pc), 32'd1023);
    cycle(0, 0, 0, 0, 0);
    chk("wrap_0", 32'(instr_pc), 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("wrap_1", 32'(instr_pc), 32'd1);

    // halt at 9, idle with noise, resume via redirect
    run_until_pc(9);
    cycle(0, 0, 0, 0, 1);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) cycle(0, bit'($urandom_range(0, 1)), 0, 0, bit'($urandom_range(0, 1)));
    chk("halt_stays", 32'(halted), 32'd1);
    cycle(0, 0, 1, 'h40, 0);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_pc", 32'(instr_pc), 32'h40);
    chk("resume_valid", 32'(instr_valid), 32'd1);

    // reset while stalled at 0x33
    cycle(0, 0, 1, 'h30, 0);
    run_until_pc('h33);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("midrst_pc", 32'(instr_pc), 32'd0);
    chk("midrst_instr", instr, 32'hA000_0000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r_rd  = $urandom_range(0, 99);
      int r_st  = $urandom_range(0, 99);
      int r_ht  = $urandom_range(0, 99);
      int r_rs  = $urandom_range(0, 199);
      int r_tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(1020, 1023) : $urandom_range(0, 1023);
      cycle(r_rs == 0, r_st < 30, r_rd < 6, r_tgt, r_ht < 4);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
